uart_tx_arbiter: RTL and testbench

Shares the single SoC UART transmitter between `NUM_REQ` byte-stream requesters (e.g. CPU peripheral path, debug/boot monitor). It sits between the requesters and the UART TX core's byte input, which feeds `peripheral_uart_tx_o`. It grants round-robin and holds each grant for a line: until a terminator byte, a burst limit or an idle timeout. Its output is a registered valid/ready byte stream.

---
 rtl/uart_arb_pkg.sv | 10 +
 rtl/uart_rr_pick.sv | 30 +++
 rtl/uart_tx_arbiter.sv | 144 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types for the UART TX arbiter. The TAG state and TAG_BASE exist only
// when UART_ARB_TAG_EN is defined.
package uart_arb_pkg;
`ifdef UART_ARB_TAG_EN
   typedef enum logic [1:0] {IDLE = 2'd0, TAG = 2'd1, XFER = 2'd2} uart_arb_state_e;
   localparam logic [7:0] TAG_BASE = 8'h30;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd2} uart_arb_state_e;
`endif
endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i,
// wrapping modulo NUM_REQ; one-hot result, zero if nothing requests.
module uart_rr_pick #(
   parameter int NUM_REQ = 2,
   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [PW-1:0]      ptr_i,
   output logic [NUM_REQ-1:0] gnt_o
);
   logic [PW:0]   sum;
   logic [PW-1:0] idx;
   logic          found;

   always_comb begin
      gnt_o = '0;
      found = 1'b0;
      sum   = '0;
      idx   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         sum = {1'b0, ptr_i} + (PW+1)'(i);
         if (sum >= (PW+1)'(NUM_REQ)) sum = sum - (PW+1)'(NUM_REQ);
         idx = sum[PW-1:0];
         if (!found && req_i[idx]) begin
            gnt_o[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART TX byte stream between NUM_REQ requesters,
// grant held per line. Define UART_ARB_TAG_EN to prefix each grant with an ASCII tag.
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int         NUM_REQ      = 2,
   parameter int         MAX_BURST    = 64,
   parameter logic [7:0] LOCK_CHAR    = 8'h0A,
   parameter int         IDLE_TIMEOUT = 1024
) (
   input  logic                 clk_i,
   input  logic                 reset_ni,
   input  logic [NUM_REQ-1:0]   req_valid_i,
   input  logic [NUM_REQ*8-1:0] req_data_i,
   output logic [NUM_REQ-1:0]   req_ready_o,
   output logic                 tx_valid_o,
   output logic [7:0]           tx_data_o,
   input  logic                 tx_ready_i,
   output logic [NUM_REQ-1:0]   grant_o,
   output logic                 busy_o
);
   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int BW = $clog2(MAX_BURST + 1);
   localparam int IW = $clog2(IDLE_TIMEOUT + 1);

   uart_arb_state_e    state_q;
   logic [NUM_REQ-1:0] grant_q;
   logic [PW-1:0]      ptr_q;
   logic [BW-1:0]      burst_q, burst_d;
   logic [IW-1:0]      idle_q, idle_d;
   logic               txv_q;
   logic [7:0]         txd_q;

   logic [NUM_REQ-1:0] pick;
   logic [PW-1:0]      pick_idx, ptr_d;
   logic [7:0]         data_g;
   logic               vld_g, slot_free, accept;

   uart_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
      .req_i (req_valid_i),
      .ptr_i (ptr_q),
      .gnt_o (pick)
   );

   always_comb begin
      data_g   = '0;
      pick_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_q[i]) data_g = req_data_i[i*8 +: 8];
         if (pick[i])    pick_idx = PW'(i);
      end
   end

`ifdef UART_ARB_TAG_EN
   logic [PW-1:0] gidx;
   always_comb begin
      gidx = '0;
      for (int i = 0; i < NUM_REQ; i++)
         if (grant_q[i]) gidx = PW'(i);
   end
`endif

   // The register slot is free if empty or draining this cycle: full throughput.
   assign slot_free   = !txv_q || tx_ready_i;
   assign req_ready_o = (state_q == XFER && slot_free) ? grant_q : '0;
   assign accept      = |(req_valid_i & req_ready_o);
   assign vld_g       = |(req_valid_i & grant_q);
   assign ptr_d       = (pick_idx == PW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
   assign burst_d     = burst_q + 1'b1;
   assign idle_d      = idle_q + 1'b1;

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q <= IDLE;
         grant_q <= '0;
         ptr_q   <= '0;
         burst_q <= '0;
         idle_q  <= '0;
         txv_q   <= 1'b0;
         txd_q   <= 8'h00;
      end else begin
         if (accept) begin
            txv_q <= 1'b1;
            txd_q <= data_g;
         end
`ifdef UART_ARB_TAG_EN
         else if (state_q == TAG && slot_free) begin
            txv_q <= 1'b1;
            txd_q <= TAG_BASE + 8'(gidx);
         end
`endif
         else if (tx_ready_i) begin
            txv_q <= 1'b0;
         end

         case (state_q)
            IDLE: begin
               if (|req_valid_i) begin
                  grant_q <= pick;
                  ptr_q   <= ptr_d;
                  burst_q <= '0;
                  idle_q  <= '0;
`ifdef UART_ARB_TAG_EN
                  state_q <= TAG;
`else
                  state_q <= XFER;
`endif
               end
            end
`ifdef UART_ARB_TAG_EN
            TAG: if (slot_free) state_q <= XFER;
`endif
            XFER: begin
               if (accept) begin
                  burst_q <= burst_d;
                  idle_q  <= '0;
                  if (data_g == LOCK_CHAR || burst_d == BW'(MAX_BURST)) begin
                     state_q <= IDLE;
                     grant_q <= '0;
                  end
               end else if (vld_g) begin
                  idle_q <= '0;
               end else begin
                  // Holder went quiet: keep the line until the timeout expires.
                  idle_q <= idle_d;
                  if (idle_d == IW'(IDLE_TIMEOUT)) begin
                     state_q <= IDLE;
                     grant_q <= '0;
                  end
               end
            end
            default: begin
               state_q <= IDLE;
               grant_q <= '0;
            end
         endcase
      end
   end

   assign grant_o    = grant_q;
   assign tx_valid_o = txv_q;
   assign tx_data_o  = txd_q;
   assign busy_o     = (state_q != IDLE) || txv_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed line scenarios plus random traffic,
// checked cycle by cycle against a queue-based reference of the arbitration rules.
module tb_uart_tx_arbiter;
   localparam int N  = 3;
   localparam int MB = 4;
   localparam int IT = 16;
`ifdef UART_ARB_TAG_EN
   localparam int TAGON = 1;
`else
   localparam int TAGON = 0;
`endif

   logic           clk_i = 1'b0;
   logic           reset_ni;
   logic [N-1:0]   req_valid_i, req_ready_o, grant_o;
   logic [N*8-1:0] req_data_i;
   logic           tx_valid_o, tx_ready_i, busy_o;
   logic [7:0]     tx_data_o;

   always #5 clk_i = ~clk_i;

   uart_tx_arbiter #(.NUM_REQ(N), .MAX_BURST(MB), .LOCK_CHAR(8'h0A), .IDLE_TIMEOUT(IT)) dut (
      .clk_i       (clk_i),
      .reset_ni    (reset_ni),
      .req_valid_i (req_valid_i),
      .req_data_i  (req_data_i),
      .req_ready_o (req_ready_o),
      .tx_valid_o  (tx_valid_o),
      .tx_data_o   (tx_data_o),
      .tx_ready_i  (tx_ready_i),
      .grant_o     (grant_o),
      .busy_o      (busy_o)
   );

   typedef struct packed {logic [N-1:0] g; logic v; logic [7:0] d;} hist_t;

   logic [7:0] rq [N][$];
   logic [N-1:0] en;
   hist_t      hist[$];
   logic [7:0] drained[$];
   logic [7:0] exp_q[$];
   int         gl[$];
   int checks = 0, errors = 0;

   // reference: st 0=no grant, 1=tag pending, 2=streaming
   int m_st, m_g, m_ptr, m_cnt, m_idle;
   bit m_txv;
   logic [7:0] m_txd;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic cyc(input bit tr);
      logic [N-1:0] v, er, eg;
      bit free, acc;
      int w, ag;
      logic [7:0] ab;
      for (int r = 0; r < N; r++) begin
         v[r] = en[r] && (rq[r].size() > 0);
         req_data_i[r*8 +: 8] = v[r] ? rq[r][0] : 8'($urandom);
      end
      req_valid_i = v;
      tx_ready_i  = tr;
      #1;
      free = !m_txv || tr;
      er = '0;
      acc = 1'b0;
      ag = 0;
      ab = 8'h00;
      if (m_st == 2) begin
         if (free) er[m_g] = 1'b1;
         acc = v[m_g] && free;
         ag = m_g;
         if (acc) ab = rq[m_g][0];
      end
      chk("req_ready", 32'(req_ready_o), 32'(er));
      if (tx_valid_o && tr) drained.push_back(tx_data_o);
      if (acc) begin
         m_txv = 1'b1; m_txd = ab;
      end else if (m_st == 1 && free) begin
         m_txv = 1'b1; m_txd = 8'h30 + 8'(m_g);
      end else if (tr) begin
         m_txv = 1'b0;
      end
      case (m_st)
         0: if (v != 0) begin
            w = m_ptr;
            while (!v[w]) w = (w + 1) % N;
            m_g = w; m_ptr = (w + 1) % N; m_cnt = 0; m_idle = 0;
            m_st = TAGON ? 1 : 2;
         end
         1: if (free) m_st = 2;
         default: begin
            if (acc) begin
               m_cnt++; m_idle = 0;
               if (ab == 8'h0A || m_cnt == MB) begin m_st = 0; m_g = -1; end
            end else if (v[m_g]) begin
               m_idle = 0;
            end else begin
               m_idle++;
               if (m_idle == IT) begin m_st = 0; m_g = -1; end
            end
         end
      endcase
      if (acc) void'(rq[ag].pop_front());
      @(posedge clk_i); #1;
      eg = '0;
      if (m_st != 0) eg[m_g] = 1'b1;
      chk("grant", 32'(grant_o), 32'(eg));
      chk("tx_valid", 32'(tx_valid_o), 32'(m_txv));
      if (m_txv) chk("tx_data", 32'(tx_data_o), 32'(m_txd));
      chk("busy", 32'(busy_o), 32'((m_st != 0) || m_txv));
      hist.push_back('{grant_o, tx_valid_o, tx_data_o});
   endtask

   task automatic model_clear();
      m_st = 0; m_g = -1; m_ptr = 0; m_cnt = 0; m_idle = 0; m_txv = 1'b0; m_txd = 8'h00;
      for (int r = 0; r < N; r++) rq[r].delete();
      en = '0; req_valid_i = '0; req_data_i = '0; tx_ready_i = 1'b0;
      hist.delete(); drained.delete();
   endtask

   task automatic do_reset();
      reset_ni = 1'b0;
      model_clear();
      @(posedge clk_i); #1;
      chk("rst_grant", 32'(grant_o), 32'd0);
      chk("rst_tx_valid", 32'(tx_valid_o), 32'd0);
      chk("rst_tx_data", 32'(tx_data_o), 32'd0);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_ready", 32'(req_ready_o), 32'd0);
      reset_ni = 1'b1;
      @(posedge clk_i); #1;
   endtask

   task automatic grants_from_hist();
      gl.delete();
      for (int i = 0; i < hist.size(); i++)
         if (hist[i].g != 0 && (i == 0 || hist[i-1].g == 0)) gl.push_back(int'(hist[i].g));
   endtask

   task automatic cmp_drained(input string tag);
      chk({tag, "_count"}, 32'(drained.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < drained.size(); i++)
         chk({tag, "_byte"}, 32'(drained[i]), 32'(exp_q[i]));
   endtask

   initial begin
      reset_ni = 1'b0;
      model_clear();
      do_reset();

      // "AB\n" from req0, tx always ready
      rq[0] = '{8'h41, 8'h42, 8'h0A}; en = 3'b001;
      repeat (8) cyc(1'b1);
      chk("ab_grant_n1", 32'(hist[0].g), 32'd1);
      chk("ab_txv_first", 32'(hist[TAGON+1].v), 32'd1);
      chk("ab_byte0", 32'(hist[TAGON+1].d), 32'h41);
      chk("ab_byte1", 32'(hist[TAGON+2].d), 32'h42);
      chk("ab_byte2", 32'(hist[TAGON+3].d), 32'h0A);
      chk("ab_grant_release", 32'(hist[TAGON+3].g), 32'd0);

      // two continuous requesters alternate line by line
      do_reset();
      rq[0] = '{8'h58, 8'h0A, 8'h58, 8'h0A}; rq[1] = '{8'h59, 8'h0A}; en = 3'b011;
      repeat (20) cyc(1'b1);
      grants_from_hist();
      chk("alt_ngrants", 32'(gl.size()), 32'd3);
      if (gl.size() >= 3) begin
         chk("alt_g0", 32'(gl[0]), 32'd1);
         chk("alt_g1", 32'(gl[1]), 32'd2);
         chk("alt_g2", 32'(gl[2]), 32'd1);
      end
`ifdef UART_ARB_TAG_EN
      exp_q = '{8'h30, 8'h58, 8'h0A, 8'h31, 8'h59, 8'h0A, 8'h30, 8'h58, 8'h0A};
`else
      exp_q = '{8'h58, 8'h0A, 8'h59, 8'h0A, 8'h58, 8'h0A};
`endif
      cmp_drained("alt");

      // burst limit: req1 unterminated, req0 pending wins next
      do_reset();
      rq[1] = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66}; en = 3'b010;
      cyc(1'b1);
      rq[0] = '{8'h6B, 8'h0A}; en = 3'b011;
      repeat (14) cyc(1'b1);
      grants_from_hist();
      chk("burst_g0", 32'(gl[0]), 32'd2);
      chk("burst_g1", 32'(gl[1]), 32'd1);
`ifdef UART_ARB_TAG_EN
      exp_q = '{8'h31, 8'h61, 8'h62, 8'h63, 8'h64, 8'h30, 8'h6B, 8'h0A, 8'h31, 8'h65, 8'h66};
`else
      exp_q = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h6B, 8'h0A, 8'h65, 8'h66};
`endif
      cmp_drained("burst");

      // idle timeout: req0 sends one byte then goes quiet
      do_reset();
      rq[0] = '{8'h51}; rq[1] = '{8'h52, 8'h0A}; en = 3'b011;
      repeat (24) cyc(1'b1);
      chk("to_hold", 32'(hist[TAGON+IT].g), 32'd1);
      chk("to_release", 32'(hist[TAGON+IT+1].g), 32'd0);
      chk("to_next", 32'(hist[TAGON+IT+2].g), 32'd2);

      // sparse tx_ready pulses
      do_reset();
      rq[0] = '{8'h61, 8'h62, 8'h0A}; en = 3'b001;
      for (int k = 0; k < 40; k++) cyc(k % 10 == 9);
`ifdef UART_ARB_TAG_EN
      exp_q = '{8'h30, 8'h61, 8'h62, 8'h0A};
`else
      exp_q = '{8'h61, 8'h62, 8'h0A};
`endif
      cmp_drained("pulse");

      // async reset mid-line with a byte stuck in the output register
      do_reset();
      rq[0] = '{8'h61, 8'h62, 8'h63, 8'h0A}; en = 3'b001;
      repeat (4) cyc(1'b0);
      chk("mid_txv_before", 32'(tx_valid_o), 32'd1);
      #2 reset_ni = 1'b0;
      #1;
      chk("arst_grant", 32'(grant_o), 32'd0);
      chk("arst_tx_valid", 32'(tx_valid_o), 32'd0);
      chk("arst_tx_data", 32'(tx_data_o), 32'd0);
      chk("arst_busy", 32'(busy_o), 32'd0);
      chk("arst_ready", 32'(req_ready_o), 32'd0);
      do_reset();
      rq[0] = '{8'h71, 8'h0A}; rq[1] = '{8'h72, 8'h0A}; en = 3'b011;
      cyc(1'b1);
      chk("arst_ptr0", 32'(hist[0].g), 32'd1);
      repeat (10) cyc(1'b1);

      // random traffic
      do_reset();
      en = 3'b111;
      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) begin do_reset(); en = 3'b111; end
         for (int r = 0; r < N; r++) begin
            if (rq[r].size() < 3 && $urandom_range(3) == 0) begin
               int len = int'($urandom_range(1, 6));
               for (int b = 0; b < len - 1; b++) rq[r].push_back(8'h41 + 8'($urandom_range(25)));
               rq[r].push_back(($urandom_range(9) < 7) ? 8'h0A : 8'h41 + 8'($urandom_range(25)));
            end
            if ($urandom_range(19) == 0) en[r] = ~en[r];
         end
         cyc($urandom_range(9) < 7);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
